// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store initiator for a data memory that samples MemRd on
// negedge and MemWr on posedge. Strobes are registered and held for exactly one cycle.
// Optional load/store counters are enabled by defining MEM_ACCESS_PERF_CNT_EN.
module mem_access_ctrl #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned MEM_DEPTH = 65536
) (
  input  logic              CLK,
  input  logic              RST_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              st_ack,
  output logic              stall,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_rd,
  output logic              mem_wr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       load_cnt,
  output logic [15:0]       store_cnt
);

  typedef enum logic [1:0] {StIdle, StAccess, StResp} state_e;

  state_e state_q, state_d;

  logic              accept;
  logic              in_range;
  logic              wr_q;
  logic              fault_q;
  logic              mem_rd_q, mem_wr_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              resp_valid_q, resp_err_q, st_ack_q;
  logic [DATA_W-1:0] resp_data_q;

  // Widened compare so the default depth (2**ADDR_W) never truncates.
  assign in_range = 64'(req_addr) < 64'(MEM_DEPTH);
  assign accept   = req_valid & req_ready;

  // State register
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Next-state logic: ACCESS always lasts one cycle; loads wait in RESP for the consumer
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (accept) state_d = StAccess;
      StAccess: state_d = wr_q ? StIdle : StResp;
      StResp:   if (resp_ready) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Handshake outputs decoded from state
  always_comb begin
    req_ready = (state_q == StIdle);
    stall     = ~req_ready;
  end

  // Datapath: memory strobes, response capture and store ack
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      wr_q         <= 1'b0;
      fault_q      <= 1'b0;
      mem_rd_q     <= 1'b0;
      mem_wr_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_data_q  <= '0;
      st_ack_q     <= 1'b0;
    end else begin
      st_ack_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          // Drops a store's one-cycle error flag along with its ack
          resp_err_q <= 1'b0;
          if (accept) begin
            wr_q    <= req_wr;
            fault_q <= ~in_range;
            if (in_range) begin
              mem_addr_q  <= req_addr;
              mem_wdata_q <= req_wdata;
              mem_rd_q    <= ~req_wr;
              mem_wr_q    <= req_wr;
            end
          end
        end
        StAccess: begin
          mem_rd_q   <= 1'b0;
          mem_wr_q   <= 1'b0;
          resp_err_q <= fault_q;
          if (wr_q) begin
            st_ack_q <= 1'b1;
          end else begin
            resp_valid_q <= 1'b1;
            resp_data_q  <= fault_q ? '0 : mem_rdata;
          end
        end
        StResp: begin
          if (resp_ready) begin
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign mem_rd     = mem_rd_q;
  assign mem_wr     = mem_wr_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_data  = resp_data_q;
  assign st_ack     = st_ack_q;

`ifdef MEM_ACCESS_PERF_CNT_EN
  logic [15:0] load_cnt_q, store_cnt_q;

  // Saturating completion counters, bumped as ACCESS retires (faulted accesses included)
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      load_cnt_q  <= '0;
      store_cnt_q <= '0;
    end else if (state_q == StAccess) begin
      if (wr_q && store_cnt_q != 16'hFFFF) store_cnt_q <= store_cnt_q + 16'd1;
      if (!wr_q && load_cnt_q != 16'hFFFF) load_cnt_q <= load_cnt_q + 16'd1;
    end
  end

  assign load_cnt  = load_cnt_q;
  assign store_cnt = store_cnt_q;
`else
  assign load_cnt  = 16'h0000;
  assign store_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven vectors, reset-abort sequence and a randomized back-to-back
// phase against a transaction-level memory model. The main DUT uses MEM_DEPTH=1024 so faults can
// be provoked; a second, default-parameter DUT shares the stimulus and must never fault.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_wr, resp_ready;
  logic [15:0] req_addr, req_wdata;

  logic        req_ready, resp_valid, resp_err, st_ack, stall, mem_rd, mem_wr;
  logic [15:0] resp_data, mem_addr, mem_wdata, mem_rdata, load_cnt, store_cnt;

  logic        req_ready2, resp_valid2, resp_err2, st_ack2, stall2, mem_rd2, mem_wr2;
  logic [15:0] resp_data2, mem_addr2, mem_wdata2, mem_rdata2, load_cnt2, store_cnt2;

  int n_tests = 0;
  int n_fail  = 0;
  int n_ld    = 0;
  int n_st    = 0;

  logic [15:0] mem     [1024];
  logic [15:0] ref_mem [1024];

  always #5 clk = ~clk;

  mem_access_ctrl #(.ADDR_W(16), .DATA_W(16), .MEM_DEPTH(1024)) dut (
    .CLK(clk), .RST_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_err(resp_err), .st_ack(st_ack), .stall(stall),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .mem_rdata(mem_rdata), .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  mem_access_ctrl dut2 (
    .CLK(clk), .RST_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready2), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid2), .resp_ready(resp_ready),
    .resp_data(resp_data2), .resp_err(resp_err2), .st_ack(st_ack2), .stall(stall2),
    .mem_addr(mem_addr2), .mem_wdata(mem_wdata2), .mem_rd(mem_rd2), .mem_wr(mem_wr2),
    .mem_rdata(mem_rdata2), .load_cnt(load_cnt2), .store_cnt(store_cnt2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory behaviour: read sampled on negedge, write on posedge
  always @(negedge clk) begin
    if (mem_rd) mem_rdata <= (mem_addr < 16'd1024) ? mem[mem_addr[9:0]] : 16'hDEAD;
    if (mem_rd2) mem_rdata2 <= mem_addr2 ^ 16'hA5A5;
  end

  logic prev_strobe = 1'b0;
  always @(posedge clk) begin
    if (mem_wr && mem_addr < 16'd1024) mem[mem_addr[9:0]] <= mem_wdata;
    if (mem_rd || mem_wr) begin
      chk("strobe_exclusive", {31'b0, mem_rd & mem_wr}, 0);
      chk("strobe_in_range", {31'b0, mem_addr < 16'd1024}, 1);
      chk("strobe_one_cycle", {31'b0, prev_strobe}, 0);
    end
    prev_strobe = mem_rd | mem_wr;
  end

  // Default depth covers the whole address space: no response may flag a fault
  always @(negedge clk) begin
    if (rst_n && (st_ack2 || resp_valid2)) chk("default_depth_no_fault", {31'b0, resp_err2}, 0);
  end

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [15:0] wdata;
    int          hold;
    logic        exp_err;
    logic [15:0] exp_data;
  } vec_t;

  typedef struct {
    logic        wr;
    logic        err;
    logic [15:0] data;
  } exp_t;

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    chk("ready_before_req", {31'b0, req_ready}, 1);
  endtask

  task automatic do_req(input vec_t v);
    logic fault;
    fault = (v.addr >= 16'd1024);
    wait_ready();
    req_valid = 1'b1; req_wr = v.wr; req_addr = v.addr; req_wdata = v.wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("access_stall", {31'b0, stall}, 1);
    chk("access_ready", {31'b0, req_ready}, 0);
    chk("access_mem_rd", {31'b0, mem_rd}, {31'b0, ~v.wr & ~fault});
    chk("access_mem_wr", {31'b0, mem_wr}, {31'b0, v.wr & ~fault});
    chk("access_mem_rd_dflt", {31'b0, mem_rd2}, {31'b0, ~v.wr});
    if (!fault) chk("access_mem_addr", {16'b0, mem_addr}, {16'b0, v.addr});
    if (v.wr && !fault) chk("access_mem_wdata", {16'b0, mem_wdata}, {16'b0, v.wdata});
    @(posedge clk); #1;
    chk("post_access_strobes", {30'b0, mem_rd, mem_wr}, 0);
    if (v.wr) begin
      chk("st_ack", {31'b0, st_ack}, 1);
      chk("st_err", {31'b0, resp_err}, {31'b0, v.exp_err});
      chk("st_no_resp", {31'b0, resp_valid}, 0);
      if (!fault) ref_mem[v.addr[9:0]] = v.wdata;
      n_st++;
      @(posedge clk); #1;
      chk("st_ack_pulse", {31'b0, st_ack}, 0);
      chk("st_err_pulse", {31'b0, resp_err}, 0);
      chk("st_back_idle", {31'b0, req_ready}, 1);
    end else begin
      chk("ld_valid", {31'b0, resp_valid}, 1);
      chk("ld_data", {16'b0, resp_data}, {16'b0, v.exp_data});
      chk("ld_err", {31'b0, resp_err}, {31'b0, v.exp_err});
      chk("ld_data_dflt", {16'b0, resp_data2}, {16'b0, v.addr ^ 16'hA5A5});
      for (int h = 0; h < v.hold; h++) begin
        @(posedge clk); #1;
        chk("hold_valid", {31'b0, resp_valid}, 1);
        chk("hold_data", {16'b0, resp_data}, {16'b0, v.exp_data});
        chk("hold_err", {31'b0, resp_err}, {31'b0, v.exp_err});
        chk("hold_stall", {30'b0, stall, req_ready}, 32'd2);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      n_ld++;
      chk("ld_done_valid", {31'b0, resp_valid}, 0);
      chk("ld_done_err", {31'b0, resp_err}, 0);
      chk("ld_done_ready", {31'b0, req_ready}, 1);
    end
  endtask

  vec_t vecs[7];
  exp_t exp_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic acc;
    logic last_wr;
    int   last_acc;
    int   n_acc;

    for (int i = 0; i < 1024; i++) begin
      mem[i]     = 16'(i * 3 + 7);
      ref_mem[i] = 16'(i * 3 + 7);
    end
    mem_rdata = '0; mem_rdata2 = '0;
    req_valid = 0; req_wr = 0; req_addr = 0; req_wdata = 0; resp_ready = 0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", {31'b0, req_ready}, 1);
    chk("rst_stall", {31'b0, stall}, 0);
    chk("rst_outputs", {27'b0, resp_valid, resp_err, st_ack, mem_rd, mem_wr}, 0);
    chk("rst_resp_data", {16'b0, resp_data}, 0);
    chk("rst_mem_addr", {16'b0, mem_addr}, 0);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{1'b1, 16'h0010, 16'hBEEF, 0, 1'b0, 16'h0000};
    vecs[1] = '{1'b0, 16'h0010, 16'h0000, 0, 1'b0, 16'hBEEF};
    vecs[2] = '{1'b0, 16'h0010, 16'h0000, 5, 1'b0, 16'hBEEF};
    vecs[3] = '{1'b0, 16'h0005, 16'h0000, 0, 1'b0, 16'h0016};
    vecs[4] = '{1'b0, 16'h0400, 16'h0000, 2, 1'b1, 16'h0000};
    vecs[5] = '{1'b1, 16'hFFFF, 16'h1111, 0, 1'b1, 16'h0000};
    vecs[6] = '{1'b0, 16'h03FF, 16'h0000, 0, 1'b0, 16'h0C04};
    for (int i = 0; i < 7; i++) do_req(vecs[i]);

    // Reset during the ACCESS cycle of a store must cancel the write
    wait_ready();
    req_valid = 1'b1; req_wr = 1'b1; req_addr = 16'h0020; req_wdata = 16'h1234;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("abort_mem_wr_before", {31'b0, mem_wr}, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_wr_dropped", {31'b0, mem_wr}, 0);
    chk("abort_ready", {31'b0, req_ready}, 1);
    n_ld = 0; n_st = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    do_req('{1'b0, 16'h0020, 16'h0000, 0, 1'b0, 16'h0067});

    // Back-to-back alternating traffic with req_valid held high
    last_wr = 1'b0; last_acc = -1; n_acc = 0;
    @(posedge clk); #1;
    req_valid = 1'b1; req_wr = 1'b1;
    req_addr = 16'($urandom_range(0, 15)); req_wdata = 16'($urandom);
    resp_ready = 1'b1;
    for (int c = 0; c < 420; c++) begin
      @(negedge clk);
      if (st_ack) begin
        if (exp_q.size() == 0) chk("rand_spurious_ack", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rand_ack_kind", {31'b0, e.wr}, 1);
          chk("rand_st_err", {31'b0, resp_err}, {31'b0, e.err});
          n_st++;
        end
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) chk("rand_spurious_resp", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("rand_resp_kind", {31'b0, e.wr}, 0);
          chk("rand_ld_data", {16'b0, resp_data}, {16'b0, e.data});
          chk("rand_ld_err", {31'b0, resp_err}, {31'b0, e.err});
          n_ld++;
        end
      end
      acc = req_valid & req_ready;
      if (acc) begin
        if (last_acc >= 0 && last_wr) chk("rand_store_spacing", c - last_acc, 2);
        else if (last_acc >= 0) chk("rand_load_spacing", {31'b0, (c - last_acc) >= 3}, 1);
        e.wr  = req_wr;
        e.err = (req_addr >= 16'd1024);
        e.data = 16'h0000;
        if (req_wr && !e.err) ref_mem[req_addr[9:0]] = req_wdata;
        if (!req_wr && !e.err) e.data = ref_mem[req_addr[9:0]];
        exp_q.push_back(e);
        last_acc = c; last_wr = req_wr; n_acc++;
      end
      @(posedge clk); #1;
      if (acc) begin
        req_wr    = ~req_wr;
        req_addr  = ($urandom_range(0, 7) == 0) ? 16'($urandom_range(1024, 65535))
                                                : 16'($urandom_range(0, 15));
        req_wdata = 16'($urandom);
        if (c >= 400) req_valid = 1'b0;
      end
      resp_ready = ($urandom_range(0, 3) != 0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rand_drained", exp_q.size(), 0);
    chk("rand_enough_accepts", {31'b0, n_acc > 80}, 1);
    chk("final_idle", {31'b0, req_ready}, 1);

`ifdef MEM_ACCESS_PERF_CNT_EN
    chk("load_cnt", {16'b0, load_cnt}, n_ld);
    chk("store_cnt", {16'b0, store_cnt}, n_st);
`else
    chk("load_cnt_tied", {16'b0, load_cnt}, 0);
    chk("store_cnt_tied", {16'b0, store_cnt}, 0);
    chk("cnt_tied_dflt", {load_cnt2, store_cnt2}, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
